mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock, rising edge.
REQ-002 SHALL have port: rst_in  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rdy_in  in  1  global ready; low freezes all state.
REQ-004 SHALL have ports: ex_reg_addr in 5 dest reg; ex_reg_data in 32 ALU result; ex_if_write in 1 regfile write enable.
REQ-005 SHALL have ports: ex_mem_op in 4 (0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; others = none); ex_mem_addr in 32; ex_store_data in 32.
REQ-006 SHALL have ports: mc_req out 1; mc_wr out 1; mc_addr out 32; mc_wdata out 8; mc_ack in 1; mc_rdata in 8 (byte-serial memory controller).
REQ-007 SHALL have ports: mem_reg_addr out 5; mem_reg_data out 32; if_write out 1 (to MEM_WB); mem_stall_req out 1 (to stall ctrl); misalign_err out 1.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE, plus 2-bit byte counter cnt and 32-bit load buffer buf.
REQ-009 IDLE, op none: mem_reg_* = ex_reg_*, if_write = ex_if_write combinationally, mem_stall_req 0, mc_req 0.
REQ-010 IDLE, memory op: mem_stall_req 1 same cycle, if_write 0; next edge -> ACCESS, cnt 0, buf 0.
REQ-011 Byte count N: 1 for B/BU/SB, 2 for H/HU/SH, 4 for W/SW.
REQ-012 ACCESS: mc_req 1, mc_addr = ex_mem_addr + cnt, mc_wr 1 for stores, mc_wdata = ex_store_data byte cnt (little-endian); held stable until mc_ack.
REQ-013 On mc_ack in ACCESS: load writes mc_rdata into buf byte cnt; if cnt = N-1 -> DONE, else cnt+1; mc_req drops for exactly one cycle between bytes.
REQ-014 DONE: mem_stall_req 0, mc_req 0; loads: if_write = ex_if_write, mem_reg_data = buf sign-extended (LB/LH) or zero-extended (LBU/LHU), LW unmodified; stores: if_write 0; next edge -> IDLE.
REQ-015 mem_stall_req SHALL be 1 in ACCESS and in IDLE-with-memory-op, 0 otherwise.
REQ-016 mc_ack outside ACCESS SHALL be ignored.
REQ-017 rdy_in low SHALL hold state, cnt, buf; mc_req/mc_addr keep values.
REQ-018 mc_addr increment SHALL wrap modulo 2^32 (0xFFFFFFFF+1 = 0).
REQ-019 Latency with single-cycle ack: SB/LB 3 cycles, SH/LH 5, SW/LW 9 from op presentation to DONE.

Reset
REQ-020 rst_in low SHALL asynchronously force IDLE, cnt 0, buf 0; while low all outputs 0 (mc_req 0, mem_stall_req 0, if_write 0, mem_reg_* 0, misalign_err 0).
REQ-021 Reset mid-ACCESS SHALL abort the transfer; no further mc_req until a new op after release.

Configuration
REQ-022 Macro MEM_MISALIGN_CHECK_EN defined: H/HU/SH with addr[0]=1 or W/SW with addr[1:0]!=0 SHALL assert misalign_err 1 in IDLE, skip ACCESS, no mc_req, if_write 0, mem_stall_req 0.
REQ-023 Macro undefined: misalign_err tied 0; misaligned accesses proceed byte-serially per REQ-012.

Verification
REQ-024 op none, ex_reg_addr 5, ex_reg_data 0x1234, ex_if_write 1 -> same-cycle mem_reg_data 0x1234, if_write 1, no mc_req.
REQ-025 LB addr 0x100, mc_rdata 0x80, 1-cycle ack -> DONE in cycle 3, mem_reg_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SW addr 0x200, data 0xAABBCCDD -> mc_addr 0x200..0x203, mc_wdata DD,CC,BB,AA, mc_wr 1, if_write 0.
REQ-027 LW with ack delayed 3 cycles per byte, rdy_in low 2 cycles mid-byte -> mc_addr stable, result exact, stall held throughout.
REQ-028 rst_in low during LW byte 2 -> all outputs 0 immediately; after release op none passes through.
REQ-029 With MEM_MISALIGN_CHECK_EN, LW addr 0x102 -> misalign_err 1, no mc_req; without, 4 byte requests 0x102..0x105.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores via a handshake memory controller.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses in IDLE.
module mem_access (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [4:0]  ex_reg_addr,
   input  logic [31:0] ex_reg_data,
   input  logic        ex_if_write,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_store_data,
   output logic        mc_req,
   output logic        mc_wr,
   output logic [31:0] mc_addr,
   output logic [7:0]  mc_wdata,
   input  logic        mc_ack,
   input  logic [7:0]  mc_rdata,
   output logic [4:0]  mem_reg_addr,
   output logic [31:0] mem_reg_data,
   output logic        if_write,
   output logic        mem_stall_req,
   output logic        misalign_err
);
   localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                          OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        gap, gap_nxt;
   logic [31:0] load_buf, load_buf_nxt;
   logic        is_load, is_store, is_mem, misaligned;
   logic [1:0]  last;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      last     = 2'd0;
      case (ex_mem_op)
         OP_LB, OP_LBU: begin is_load  = 1'b1; last = 2'd0; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; last = 2'd1; end
         OP_LW:         begin is_load  = 1'b1; last = 2'd3; end
         OP_SB:         begin is_store = 1'b1; last = 2'd0; end
         OP_SH:         begin is_store = 1'b1; last = 2'd1; end
         OP_SW:         begin is_store = 1'b1; last = 2'd3; end
         default:       ;
      endcase
      is_mem = is_load | is_store;
`ifdef MEM_MISALIGN_CHECK_EN
      // last is 1 for halfwords and 3 for words, so it doubles as the alignment mask
      misaligned = |(ex_mem_addr[1:0] & last);
`else
      misaligned = 1'b0;
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         gap      <= 1'b0;
         load_buf <= 32'd0;
      end else if (rdy_in) begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         gap      <= gap_nxt;
         load_buf <= load_buf_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      gap_nxt      = gap;
      load_buf_nxt = load_buf;
      case (state)
         IDLE: begin
            if (is_mem && !misaligned) begin
               state_nxt    = ACCESS;
               cnt_nxt      = 2'd0;
               gap_nxt      = 1'b0;
               load_buf_nxt = 32'd0;
            end
         end
         ACCESS: begin
            // gap is the mandatory one-cycle request drop between bytes
            if (gap) begin
               gap_nxt = 1'b0;
            end else if (mc_ack) begin
               if (is_load) load_buf_nxt[{cnt, 3'b000} +: 8] = mc_rdata;
               if (cnt == last) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt + 2'd1;
                  gap_nxt = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mc_req        = 1'b0;
      mc_wr         = 1'b0;
      mc_addr       = 32'd0;
      mc_wdata      = 8'd0;
      mem_reg_addr  = 5'd0;
      mem_reg_data  = 32'd0;
      if_write      = 1'b0;
      mem_stall_req = 1'b0;
      misalign_err  = 1'b0;
      if (rst_in) begin
         mem_reg_addr = ex_reg_addr;
         mem_reg_data = ex_reg_data;
         case (state)
            IDLE: begin
               if (!is_mem)        if_write      = ex_if_write;
               else if (misaligned) misalign_err  = 1'b1;
               else                mem_stall_req = 1'b1;
            end
            ACCESS: begin
               mem_stall_req = 1'b1;
               mc_req        = ~gap;
               mc_wr         = is_store;
               mc_addr       = ex_mem_addr + {30'd0, cnt};
               mc_wdata      = ex_store_data[{cnt, 3'b000} +: 8];
            end
            DONE: begin
               if (is_load) begin
                  if_write = ex_if_write;
                  case (ex_mem_op)
                     OP_LB:   mem_reg_data = {{24{load_buf[7]}}, load_buf[7:0]};
                     OP_LH:   mem_reg_data = {{16{load_buf[15]}}, load_buf[15:0]};
                     OP_LBU:  mem_reg_data = {24'd0, load_buf[7:0]};
                     OP_LHU:  mem_reg_data = {16'd0, load_buf[15:0]};
                     default: mem_reg_data = load_buf;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access with a transaction-level model of byte-serial accesses.
module tb_mem_access;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic [4:0]  ex_reg_addr = '0;
   logic [31:0] ex_reg_data = '0;
   logic        ex_if_write = 1'b0;
   logic [3:0]  ex_mem_op = '0;
   logic [31:0] ex_mem_addr = '0;
   logic [31:0] ex_store_data = '0;
   logic        mc_req, mc_wr;
   logic [31:0] mc_addr;
   logic [7:0]  mc_wdata;
   logic        mc_ack = 1'b0;
   logic [7:0]  mc_rdata = '0;
   logic [4:0]  mem_reg_addr;
   logic [31:0] mem_reg_data;
   logic        if_write, mem_stall_req, misalign_err;

   int checks = 0;
   int errors = 0;

   mem_access dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .ex_reg_addr(ex_reg_addr), .ex_reg_data(ex_reg_data), .ex_if_write(ex_if_write),
      .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
      .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_ack(mc_ack), .mc_rdata(mc_rdata),
      .mem_reg_addr(mem_reg_addr), .mem_reg_data(mem_reg_data), .if_write(if_write),
      .mem_stall_req(mem_stall_req), .misalign_err(misalign_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {31'd0, |{mc_req, mc_wr, mc_addr, mc_wdata, mem_reg_addr, mem_reg_data,
                       if_write, mem_stall_req, misalign_err}};
   endfunction

   // One complete operation: presents it, plays the memory controller, checks the result.
   task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rword, input int delay, input int freeze_pct,
                        input int freeze_cycle);
      int n, idx, waited, cycles;
      bit st, misal, frozen, done;
      logic [4:0]  ra;
      logic [31:0] rd, val, exp, ea;
      logic        iw;
      ra = 5'($urandom); rd = $urandom; iw = 1'($urandom);
      n  = (op == 1 || op == 4 || op == 6) ? 1 :
           (op == 2 || op == 5 || op == 7) ? 2 :
           (op == 3 || op == 8) ? 4 : 0;
      st = (op >= 6 && op <= 8);
`ifdef MEM_MISALIGN_CHECK_EN
      misal = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'd0);
`else
      misal = 1'b0;
`endif
      @(posedge clk_in); #1;
      ex_reg_addr = ra; ex_reg_data = rd; ex_if_write = iw;
      ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
      rdy_in = 1'b1; mc_ack = 1'b0;
      if (n == 0) begin
         mc_ack = 1'($urandom);  // stray acks while idle must do nothing
         #1;
         chk("none_data", mem_reg_data, rd);
         chk("none_addr", {27'd0, mem_reg_addr}, {27'd0, ra});
         chk("none_wr", {31'd0, if_write}, {31'd0, iw});
         chk("none_req", {31'd0, mc_req}, 32'd0);
         chk("none_stall", {31'd0, mem_stall_req}, 32'd0);
         return;
      end
      #1;
      if (misal) begin
         chk("mis_err", {31'd0, misalign_err}, 32'd1);
         chk("mis_req", {31'd0, mc_req}, 32'd0);
         chk("mis_stall", {31'd0, mem_stall_req}, 32'd0);
         chk("mis_wr", {31'd0, if_write}, 32'd0);
         return;
      end
      chk("c1_stall", {31'd0, mem_stall_req}, 32'd1);
      chk("c1_wr", {31'd0, if_write}, 32'd0);
      chk("c1_req", {31'd0, mc_req}, 32'd0);
      idx = 0; waited = 0; cycles = 1; frozen = 0; done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk_in); #1;
         mc_ack = 1'b0;
         cycles++;
         rdy_in = !((cycles == freeze_cycle) || (cycles == freeze_cycle + 1) ||
                    ($urandom_range(99) < freeze_pct));
         if (!rdy_in) frozen = 1;
         #1;
         if (!mem_stall_req) begin
            done = 1;
            rdy_in = 1'b1;
            chk("done_bytes", idx, n);
            chk("done_req", {31'd0, mc_req}, 32'd0);
            if (delay == 0 && !frozen) chk("latency", cycles, 2 * n + 1);
            if (st) begin
               chk("st_wr", {31'd0, if_write}, 32'd0);
            end else begin
               val = rword;
               if (n == 1) val = val & 32'h0000_00FF;
               if (n == 2) val = val & 32'h0000_FFFF;
               exp = val;
               if (op == 1 && val[7])  exp = val | 32'hFFFF_FF00;
               if (op == 2 && val[15]) exp = val | 32'hFFFF_0000;
               chk("ld_data", mem_reg_data, exp);
               chk("ld_wr", {31'd0, if_write}, {31'd0, iw});
            end
         end else begin
            if (if_write !== 1'b0) chk("stall_wr", {31'd0, if_write}, 32'd0);
            if (mc_req) begin
               ea = addr + 32'(idx);
               chk("mc_addr", mc_addr, ea);
               chk("mc_wr", {31'd0, mc_wr}, {31'd0, st});
               if (st) chk("mc_wdata", {24'd0, mc_wdata}, {24'd0, sdata[8*idx +: 8]});
               if (rdy_in && waited >= delay) begin
                  mc_ack = 1'b1;
                  mc_rdata = st ? 8'($urandom) : rword[8*idx +: 8];
                  idx++;
                  waited = 0;
               end else if (rdy_in) begin
                  waited++;
               end
            end
         end
      end
      if (!done) chk("timeout", 32'd0, 32'd1);
      mc_ack = 1'b0;
      rdy_in = 1'b1;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] addr;
      ex_reg_addr = 5'd7; ex_reg_data = 32'hDEAD_BEEF; ex_if_write = 1'b1;
      #2;
      chk("reset_outs", all_outs(), 32'd0);
      #20 rst_in = 1'b1;

      do_op(4'd0, 32'd0, 32'd0, 32'd0, 0, 0, -1);
      @(posedge clk_in); #1;
      ex_mem_op = 4'd0; ex_reg_addr = 5'd5; ex_reg_data = 32'h1234; ex_if_write = 1'b1;
      #1;
      chk("r24_data", mem_reg_data, 32'h1234);
      chk("r24_wr", {31'd0, if_write}, 32'd1);
      chk("r24_req", {31'd0, mc_req}, 32'd0);

      do_op(4'd1, 32'h100, 32'd0, 32'h0000_0080, 0, 0, -1);
      do_op(4'd4, 32'h100, 32'd0, 32'h0000_0080, 0, 0, -1);
      do_op(4'd8, 32'h200, 32'hAABB_CCDD, 32'd0, 0, 0, -1);
      do_op(4'd2, 32'h10, 32'd0, 32'h0000_9abc, 0, 0, -1);
      do_op(4'd7, 32'h20, 32'h1122_3344, 32'd0, 0, 0, -1);
      do_op(4'd3, 32'h300, 32'd0, 32'h8765_4321, 3, 0, 4);
      do_op(4'd3, 32'h102, 32'd0, 32'hCAFE_F00D, 0, 0, -1);
      do_op(4'd3, 32'hFFFF_FFFE, 32'd0, 32'h0102_0304, 0, 0, -1);

      // reset during the second byte of a word load
      @(posedge clk_in); #1;
      ex_mem_op = 4'd3; ex_mem_addr = 32'h400; ex_if_write = 1'b1; mc_ack = 1'b0;
      @(posedge clk_in); #1; mc_ack = 1'b1; mc_rdata = 8'h11;
      @(posedge clk_in); #1; mc_ack = 1'b0;
      @(posedge clk_in); #2;
      chk("rst_pre_addr", mc_addr, 32'h401);
      rst_in = 1'b0;
      #1;
      chk("rst_mid_outs", all_outs(), 32'd0);
      @(posedge clk_in); #1;
      rst_in = 1'b1; ex_mem_op = 4'd0; ex_reg_data = 32'h5555; ex_if_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rst_after_req", {31'd0, mc_req}, 32'd0);
         chk("rst_after_data", mem_reg_data, 32'h5555);
         @(posedge clk_in); #1;
      end

      for (int i = 0; i < 40; i++) begin
         op   = 4'($urandom_range(15));
         addr = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3)) : $urandom;
         do_op(op, addr, $urandom, $urandom, $urandom_range(3), 20, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
